pio_fir_filter: RTL



---
 rtl/pio_fir_filter.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pio_fir_filter.sv
`default_nettype none
//==============================================================================
// Module      : pio_fir_filter
// Description : Multi-channel sequential FIR (one tap per cycle) behind a
//               toggle-handshake 32-bit PIO command word.
// Revision    : 1.0 - initial release
//==============================================================================
module pio_fir_filter #(
    parameter int DATA_W    = 12,
    parameter int COEF_W    = 12,
    parameter int TAPS      = 8,
    parameter int CHANNELS  = 2,
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inp,
    output logic [OUT_W-1:0] outp,
    output logic             busy,
    output logic             overflow
);

    localparam int RES_W  = OUT_W - 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS) + 1;
    localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PAY_W  = (DATA_W > COEF_W) ? DATA_W : COEF_W;

    localparam logic [1:0] c_cmd_loadc = 2'b00;
    localparam logic [1:0] c_cmd_push  = 2'b01;
    localparam logic [1:0] c_cmd_clr   = 2'b10;
    localparam logic [1:0] c_cmd_rd    = 2'b11;

    localparam logic [3:0] c_st_idle  = 4'd0;
    localparam logic [3:0] c_st_latch = 4'd1;
    localparam logic [3:0] c_st_loadc = 4'd2;
    localparam logic [3:0] c_st_shift = 4'd3;
    localparam logic [3:0] c_st_mac   = 4'd4;
    localparam logic [3:0] c_st_sat   = 4'd5;
    localparam logic [3:0] c_st_clr   = 4'd6;
    localparam logic [3:0] c_st_rd    = 4'd7;
    localparam logic [3:0] c_st_ack   = 4'd8;

    localparam logic [5:0]       c_taps_lim = 6'(TAPS);
    localparam logic [5:0]       c_ch_lim   = 6'(CHANNELS);
    localparam logic [TAP_W-1:0] c_tap_last = TAP_W'(TAPS - 1);

    localparam logic signed [ACC_W-1:0] c_res_max = {{(ACC_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_res_min = {{(ACC_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

    logic                     r_req_meta;
    logic                     r_req_sync;
    logic                     r_req_serviced;
    logic [3:0]               r_state;
    logic [3:0]               w_state_next;
    logic [4:0]               r_idx;
    logic [PAY_W-1:0]         r_payload;
    logic [TAP_W-1:0]         r_tap;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [COEF_W-1:0] r_coef [TAPS];
    logic signed [DATA_W-1:0] r_x    [CHANNELS][TAPS];
    logic [RES_W-1:0]         r_res  [CHANNELS];
    logic [RES_W-1:0]         r_result;
    logic                     r_ack;
    logic                     r_overflow;

    logic [1:0]               w_in_cmd;
    logic [4:0]               w_in_idx;
    logic                     w_in_valid;
    logic [CH_W-1:0]          w_ch;
    logic [TAP_W-1:0]         w_coef_idx;
    logic signed [DATA_W-1:0] w_x_sel;
    logic signed [COEF_W-1:0] w_coef_sel;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_shifted;
    logic                     w_sat_hi;
    logic                     w_sat_lo;
    logic [RES_W-1:0]         w_sat_val;
    logic                     w_unused;

    assign w_in_cmd   = inp[30:29];
    assign w_in_idx   = inp[28:24];
    assign w_ch       = r_idx[CH_W-1:0];
    assign w_coef_idx = r_idx[TAP_W-1:0];
    assign w_unused   = ^{inp, r_idx};

    assign w_x_sel    = r_x[w_ch][r_tap];
    assign w_coef_sel = r_coef[r_tap];
    assign w_prod     = w_x_sel * w_coef_sel;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    assign w_shifted  = r_acc >>> FRAC_BITS;
    assign w_sat_hi   = (w_shifted > c_res_max);
    assign w_sat_lo   = (w_shifted < c_res_min);
    assign w_sat_val  = w_sat_hi ? c_res_max[RES_W-1:0] :
                        w_sat_lo ? c_res_min[RES_W-1:0] : w_shifted[RES_W-1:0];

    assign outp     = {r_ack, r_result};
    assign busy     = (r_state != c_st_idle);
    assign overflow = r_overflow;

    // Range check is done on the live word so a bad index goes straight to ACK.
    always_comb begin
        w_in_valid = 1'b1;
        case (w_in_cmd)
            c_cmd_loadc: w_in_valid = ({1'b0, w_in_idx} < c_taps_lim);
            c_cmd_push,
            c_cmd_rd:    w_in_valid = ({1'b0, w_in_idx} < c_ch_lim);
            default:     w_in_valid = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_meta <= 1'b0;
            r_req_sync <= 1'b0;
        end else begin
            r_req_meta <= inp[31];
            r_req_sync <= r_req_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (r_req_sync != r_req_serviced) begin
                    w_state_next = c_st_latch;
                end
            end
            c_st_latch: begin
                if (!w_in_valid) begin
                    w_state_next = c_st_ack;
                end else begin
                    case (w_in_cmd)
                        c_cmd_loadc: w_state_next = c_st_loadc;
                        c_cmd_push:  w_state_next = c_st_shift;
                        c_cmd_clr:   w_state_next = c_st_clr;
                        default:     w_state_next = c_st_rd;
                    endcase
                end
            end
            c_st_shift: w_state_next = c_st_mac;
            c_st_mac: begin
                if (r_tap == c_tap_last) begin
                    w_state_next = c_st_sat;
                end
            end
            c_st_loadc,
            c_st_sat,
            c_st_clr,
            c_st_rd:   w_state_next = c_st_ack;
            c_st_ack:  w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_serviced <= 1'b0;
            r_idx          <= '0;
            r_payload      <= '0;
            r_tap          <= '0;
            r_acc          <= '0;
            r_result       <= '0;
            r_ack          <= 1'b0;
            r_overflow     <= 1'b0;
            for (int t = 0; t < TAPS; t++) begin
                r_coef[t] <= '0;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                r_res[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    r_x[c][t] <= '0;
                end
            end
        end else begin
            case (r_state)
                c_st_latch: begin
                    r_idx          <= inp[28:24];
                    r_payload      <= inp[PAY_W-1:0];
                    r_req_serviced <= r_req_sync;
                end
                c_st_loadc: begin
                    r_coef[w_coef_idx] <= r_payload[COEF_W-1:0];
                end
                c_st_shift: begin
                    for (int t = TAPS - 1; t > 0; t--) begin
                        r_x[w_ch][t] <= r_x[w_ch][t-1];
                    end
                    r_x[w_ch][0] <= r_payload[DATA_W-1:0];
                    r_acc        <= '0;
                    r_tap        <= '0;
                end
                c_st_mac: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_tap != c_tap_last) begin
                        r_tap <= r_tap + TAP_W'(1);
                    end
                end
                c_st_sat: begin
                    r_res[w_ch] <= w_sat_val;
                    r_result    <= w_sat_val;
                    if (w_sat_hi || w_sat_lo) begin
                        r_overflow <= 1'b1;
                    end
                end
                c_st_clr: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        r_res[c] <= '0;
                        for (int t = 0; t < TAPS; t++) begin
                            r_x[c][t] <= '0;
                        end
                    end
                    r_overflow <= 1'b0;
                    r_result   <= '0;
                end
                c_st_rd: begin
                    r_result <= r_res[w_ch];
                end
                c_st_ack: begin
                    r_ack <= ~r_ack;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
